// File: rtl/alu_pkg.sv
// alu_pkg: control codes, funct codes, muldiv FSM states and the ALUOp/Funct decoder.
package alu_pkg;
   localparam logic [3:0] CTL_AND  = 4'b0000;
   localparam logic [3:0] CTL_OR   = 4'b0001;
   localparam logic [3:0] CTL_ADD  = 4'b0010;
   localparam logic [3:0] CTL_XOR  = 4'b0011;
   localparam logic [3:0] CTL_SUB  = 4'b0110;
   localparam logic [3:0] CTL_SLT  = 4'b0111;
   localparam logic [3:0] CTL_SLTU = 4'b1000;
   localparam logic [3:0] CTL_SLL  = 4'b1001;
   localparam logic [3:0] CTL_SRL  = 4'b1010;
   localparam logic [3:0] CTL_SRA  = 4'b1011;
   localparam logic [3:0] CTL_NOR  = 4'b1100;

   localparam logic [5:0] F_SLL   = 6'b000000;
   localparam logic [5:0] F_SRL   = 6'b000010;
   localparam logic [5:0] F_SRA   = 6'b000011;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_ADDU  = 6'b100001;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_SUBU  = 6'b100011;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_XOR   = 6'b100110;
   localparam logic [5:0] F_NOR   = 6'b100111;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_SLTU  = 6'b101011;

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} md_state_t;

   typedef struct packed {
      logic [3:0] ctrl;
      logic       is_muldiv;
      logic       is_signed;
      logic       is_div;
      logic       has_ovf;
      logic       illegal;
      logic       mfhi;
      logic       mflo;
   } dec_t;

   function automatic dec_t decode(input logic [1:0] alu_op, input logic [5:0] funct);
      dec_t d;
      d      = '0;
      d.ctrl = CTL_ADD;
      if (alu_op == 2'b01) d.ctrl = CTL_SUB;
      else if (alu_op == 2'b11) d.illegal = 1'b1;
      else if (alu_op == 2'b10)
         case (funct)
            F_ADD:   d.has_ovf = 1'b1;
            F_ADDU:  d.ctrl = CTL_ADD;
            F_SUB:   begin d.ctrl = CTL_SUB; d.has_ovf = 1'b1; end
            F_SUBU:  d.ctrl = CTL_SUB;
            F_AND:   d.ctrl = CTL_AND;
            F_OR:    d.ctrl = CTL_OR;
            F_XOR:   d.ctrl = CTL_XOR;
            F_NOR:   d.ctrl = CTL_NOR;
            F_SLT:   d.ctrl = CTL_SLT;
            F_SLTU:  d.ctrl = CTL_SLTU;
            F_SLL:   d.ctrl = CTL_SLL;
            F_SRL:   d.ctrl = CTL_SRL;
            F_SRA:   d.ctrl = CTL_SRA;
            F_MFHI:  d.mfhi = 1'b1;
            F_MFLO:  d.mflo = 1'b1;
            F_MULT:  begin d.is_muldiv = 1'b1; d.is_signed = 1'b1; end
            F_MULTU: d.is_muldiv = 1'b1;
            F_DIV:   begin d.is_muldiv = 1'b1; d.is_signed = 1'b1; d.is_div = 1'b1; end
            F_DIVU:  begin d.is_muldiv = 1'b1; d.is_div = 1'b1; end
            default: d.illegal = 1'b1;
         endcase
      return d;
   endfunction
endpackage

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative shift-add multiply / restoring divide on magnitudes, signs fixed up in FIX.
module alu_muldiv import alu_pkg::*; #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             signed_i,
   input  logic             div_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);
   localparam int CW = $clog2(WIDTH);
   md_state_t          r_state, w_next;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_acc, w_mul_step, w_div_step, w_prod;
   logic [WIDTH-1:0]   r_m, r_a, r_hi, r_lo, w_ma, w_mb, w_hi, w_lo;
   logic [WIDTH:0]     w_add, w_trial;
   logic               r_neg_q, r_neg_r, r_bz, r_div;

   assign busy_o = r_state != IDLE;
   assign done_o = (r_state == FIX) & ~reset;
   assign hi_o   = r_hi;
   assign lo_o   = r_lo;

   always_comb begin
      w_next = r_state;
      if (r_state == IDLE && start) w_next = div_i ? DIV : MUL;
      else if ((r_state == MUL || r_state == DIV) && &r_cnt) w_next = FIX;
      else if (r_state == FIX) w_next = IDLE;
   end

   // r_acc holds {partial product hi, multiplier} for MUL and {remainder, quotient} for DIV
   always_comb begin
      w_ma       = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
      w_mb       = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
      w_add      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_acc[0] ? r_m : {WIDTH{1'b0}}};
      w_mul_step = {w_add, r_acc[WIDTH-1:1]};
      w_trial    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_m};
      w_div_step = w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0} : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      w_prod     = r_neg_q ? -r_acc : r_acc;
      w_lo       = !r_div ? w_prod[WIDTH-1:0] : r_bz ? {WIDTH{1'b1}} : r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      w_hi       = !r_div ? w_prod[2*WIDTH-1:WIDTH] : r_bz ? r_a : r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_m     <= '0;
         r_a     <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_bz    <= 1'b0;
         r_div   <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && start) begin
            r_cnt   <= '0;
            r_acc   <= {{WIDTH{1'b0}}, div_i ? w_ma : w_mb};
            r_m     <= div_i ? w_mb : w_ma;
            r_a     <= a_i;
            r_neg_q <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            r_neg_r <= signed_i & a_i[WIDTH-1];
            r_bz    <= b_i == '0;
            r_div   <= div_i;
         end else if (r_state == MUL || r_state == DIV) begin
            r_acc <= r_state == MUL ? w_mul_step : w_div_step;
            r_cnt <= r_cnt + 1'b1;
         end else if (r_state == FIX) begin
            r_hi <= w_hi;
            r_lo <= w_lo;
         end
      end
   end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with registered single-cycle results and an iterative HI/LO path.
module alu_exec_unit import alu_pkg::*; #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [1:0]       alu_op_i,
   input  logic [5:0]       funct_i,
   input  logic [SHW-1:0]   shamt_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] result_o,
   output logic             result_valid_o,
   output logic             zero_o,
   output logic             overflow_o,
   output logic             illegal_o,
   output logic             hilo_done_o
);
   dec_t             w_dec;
   logic             w_acc, w_busy, w_ovf;
   logic [WIDTH-1:0] w_bp, w_sum, w_alu, w_res, w_hi, w_lo;
   logic [WIDTH-1:0] r_res;
   logic             r_rv, r_zero, r_ovf, r_ill;

   assign w_dec          = decode(alu_op_i, funct_i);
   assign ready_o        = ~w_busy;
   assign w_acc          = valid_i & ready_o;
   assign result_o       = r_res;
   assign result_valid_o = r_rv;
   assign zero_o         = r_zero;
   assign overflow_o     = r_ovf;
   assign illegal_o      = r_ill;

   always_comb begin
      w_bp = w_dec.ctrl == CTL_SUB ? ~b_i + 1'b1 : b_i;
      w_sum = a_i + w_bp;
      w_ovf = w_dec.has_ovf & (a_i[WIDTH-1] == w_bp[WIDTH-1]) & (w_sum[WIDTH-1] != a_i[WIDTH-1]);
      case (w_dec.ctrl)
         CTL_AND:  w_alu = a_i & b_i;
         CTL_OR:   w_alu = a_i | b_i;
         CTL_XOR:  w_alu = a_i ^ b_i;
         CTL_NOR:  w_alu = ~(a_i | b_i);
         CTL_SLT:  w_alu = WIDTH'($signed(a_i) < $signed(b_i));
         CTL_SLTU: w_alu = WIDTH'(a_i < b_i);
         CTL_SLL:  w_alu = b_i << shamt_i;
         CTL_SRL:  w_alu = b_i >> shamt_i;
         CTL_SRA:  w_alu = $signed(b_i) >>> shamt_i;
         default:  w_alu = w_sum;
      endcase
      w_res = w_dec.illegal ? '0 : w_dec.mfhi ? w_hi : w_dec.mflo ? w_lo : w_alu;
   end

   alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk      (clk),
      .reset    (reset),
      .start    (w_acc & w_dec.is_muldiv),
      .signed_i (w_dec.is_signed),
      .div_i    (w_dec.is_div),
      .a_i      (a_i),
      .b_i      (b_i),
      .busy_o   (w_busy),
      .done_o   (hilo_done_o),
      .hi_o     (w_hi),
      .lo_o     (w_lo)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_res  <= '0;
         r_rv   <= 1'b0;
         r_zero <= 1'b0;
         r_ovf  <= 1'b0;
         r_ill  <= 1'b0;
      end else begin
         r_rv  <= w_acc & ~w_dec.is_muldiv;
         r_ill <= w_acc & w_dec.illegal;
         if (w_acc && !w_dec.is_muldiv) begin
            r_res  <= w_res;
            r_zero <= w_res == '0;
            r_ovf  <= w_ovf;
         end
      end
   end
endmodule
